// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmem_state_t  : responder FSM state encoding
//   dmem_req_t    : latched load/store request payload
//   dmem_addr_err : alignment / range fault check for a byte address
package dmem_pkg;

    localparam int unsigned DMEM_WORD_W = 32;
    localparam int unsigned DMEM_STRB_W = 4;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_WORD_W-1:0] wdata;
        logic [DMEM_STRB_W-1:0] wstrb;
    } dmem_req_t;

    // Fault when the address is not word aligned or the word index is past the array.
    function automatic logic dmem_addr_err(input logic [DMEM_ADDR_W-1:0] addr,
                                           input int unsigned            depth);
        logic [DMEM_ADDR_W-1:0] word_idx;
        word_idx = {2'b00, addr[DMEM_ADDR_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= DMEM_ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit synchronous RAM with byte-lane write enables.
//   clk   : clock
//   en    : access enable; read and (optional) write happen on this edge
//   we    : write enable, qualified by wstrb
//   wstrb : byte-lane enables, bit i covers wdata[8i+7:8i]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write)
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DMEM_STRB_W-1:0] wstrb,
    input  logic [AW-1:0]          addr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem_q [DEPTH];
    logic [DMEM_WORD_W-1:0] rdata_q;
    logic [DMEM_WORD_W-1:0] rdata_d;

    // Read register only updates on an access so the response holds while stalled.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    // Storage is intentionally unreset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(DMEM_STRB_W); i++) begin
                if (wstrb[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states,
// valid/ready request and response channels.
//   clk, reset_n            : clock, async active-low reset
//   req_valid / req_ready   : request handshake
//   req_we, req_addr,
//   req_wdata, req_wstrb    : request payload (sampled only on acceptance)
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_err      : load data (0 for stores/faults) and fault flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [DMEM_ADDR_W-1:0] req_addr,
    input  logic [DMEM_WORD_W-1:0] req_wdata,
    input  logic [DMEM_STRB_W-1:0] req_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_WORD_W-1:0] rsp_rdata,
    output logic                   rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
        DMEM_CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    dmem_state_t            state_q, state_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t              req_q, req_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   load_ok_q, load_ok_d;

    dmem_req_t              req_in;
    dmem_req_t              acc;
    logic                   acc_fire;
    logic                   acc_err;
    logic [DMEM_WORD_W-1:0] arr_rdata;

    assign req_in.we    = req_we;
    assign req_in.addr  = req_addr;
    assign req_in.wdata = req_wdata;
    assign req_in.wstrb = req_wstrb;

    // Next-state, access strobe and response register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rsp_err_d = rsp_err_q;
        load_ok_d = load_ok_q;
        acc       = req_q;
        acc_fire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = req_in;
                    if (LATENCY == 0) begin
                        // Zero wait states: the acceptance edge is also the access edge.
                        acc      = req_in;
                        acc_fire = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - DMEM_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_err = dmem_addr_err(acc.addr, DEPTH);

        if (acc_fire) begin
            rsp_err_d = acc_err;
            load_ok_d = !acc.we && !acc_err;
        end

        // Handshake outputs are registered copies of the next state.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            load_ok_q   <= load_ok_d;
        end
    end

    // Faulting accesses never touch the array.
    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (acc_fire && !acc_err),
        .we    (acc.we),
        .wstrb (acc.wstrb),
        .addr  (acc.addr[AW+1:2]),
        .wdata (acc.wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Stores, faults and reset present zero; the array read register holds the load word.
    assign rsp_rdata = load_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=0) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 0;

    logic        clk;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        dmem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? LAT_A : LAT_B)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %h want %h", name, g, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int g);
        total++;
        bad++;
        $display("FAIL %s lane%0d: got timeout want response", name, g);
    endtask

    function automatic int lane_lat(input int g);
        return (g == 0) ? int'(LAT_A) : int'(LAT_B);
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [31:0] m_mem   [2][DEPTH];
    logic [3:0]  m_known [2][DEPTH];
    bit          m_busy  [2];
    int          m_due   [2];
    logic [31:0] m_rd    [2];
    bit          m_err   [2];
    bit          m_rd_ok [2];
    bit          m_st    [2];
    logic [AW-1:0] m_idx [2];
    logic [31:0] m_wd    [2];
    logic [3:0]  m_ws    [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 0;
            for (int w = 0; w < int'(DEPTH); w++) m_known[g][w] = 4'h0;
        end
    end

    task automatic model_step(input int g);
        bit          exp_valid;
        logic [31:0] a;
        logic [AW-1:0] idx;
        if (!reset_n) begin
            chk("rst_req_ready", g, 32'(req_ready[g]), 32'd1);
            chk("rst_rsp_valid", g, 32'(rsp_valid[g]), 32'd0);
            chk("rst_rsp_rdata", g, rsp_rdata[g], 32'd0);
            chk("rst_rsp_err",   g, 32'(rsp_err[g]), 32'd0);
            m_busy[g] = 0;
            return;
        end
        exp_valid = m_busy[g] && (cyc >= m_due[g]);
        chk("req_ready", g, 32'(req_ready[g]), 32'(!m_busy[g]));
        chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(exp_valid));
        if (exp_valid) begin
            if (m_st[g]) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_ws[g][i]) begin
                        m_mem[g][m_idx[g]][8*i +: 8] = m_wd[g][8*i +: 8];
                        m_known[g][m_idx[g]][i] = 1'b1;
                    end
                end
                m_st[g] = 0;
            end
            chk("rsp_err", g, 32'(rsp_err[g]), 32'(m_err[g]));
            if (m_rd_ok[g]) chk("rsp_rdata", g, rsp_rdata[g], m_rd[g]);
            if (rsp_ready[g]) m_busy[g] = 0;
        end else if (!m_busy[g] && req_valid[g]) begin
            a   = req_addr[g];
            idx = AW'(a >> 2);
            m_busy[g]  = 1;
            m_due[g]   = cyc + lane_lat(g) + 1;
            m_st[g]    = 0;
            m_err[g]   = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
            m_rd[g]    = 32'd0;
            m_rd_ok[g] = 1;
            if (!m_err[g]) begin
                if (req_we[g]) begin
                    m_st[g]  = 1;
                    m_idx[g] = idx;
                    m_wd[g]  = req_wdata[g];
                    m_ws[g]  = req_wstrb[g];
                end else begin
                    m_rd[g]    = m_mem[g][idx];
                    m_rd_ok[g] = (m_known[g][idx] == 4'hF);
                end
            end
        end
    endtask

    // Single compare process, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) model_step(g);
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 after the response handshake.
    task automatic txn(input int g, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int hold, input bit nxt, input logic [31:0] nxt_addr,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = 0;
        req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = addr;
        req_wdata[g] = wdata; req_wstrb[g] = strb;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[g] && n < 50);
        if (!req_ready[g]) begin
            fail_now("accept_timeout", g);
            req_valid[g] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (nxt) begin
            req_we[g] = 1'b0; req_addr[g] = nxt_addr;
        end else begin
            req_valid[g] = 1'b0; req_we[g] = 1'($urandom); req_addr[g] = $urandom;
            req_wdata[g] = $urandom; req_wstrb[g] = 4'($urandom);
        end
        do begin @(negedge clk); lat++; end while (!rsp_valid[g] && lat < 40);
        if (!rsp_valid[g]) begin
            fail_now("rsp_timeout", g);
            return;
        end
        rd = rsp_rdata[g];
        er = rsp_err[g];
        repeat (hold) @(negedge clk);
        @(posedge clk); #1; rsp_ready[g] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; rsp_ready[g] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12)       return 32'($urandom_range(0, 7)) << 2;
        else if (r == 12) return (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 13) return (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2;
        else if (r == 14) return $urandom;
        else              return 32'(DEPTH - 1) << 2;
    endfunction

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        reset_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0;
            req_wdata[g] = '0; req_wstrb[g] = '0; rsp_ready[g] = 1'b0;
        end
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("idle_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("idle_rsp_rdata", 0, rsp_rdata[0], 32'd0);
        chk("idle_rsp_err",   0, 32'(rsp_err[0]), 32'd0);
        @(posedge clk); #1;

        // Lane 0, LATENCY=2
        txn(0, 1'b1, 32'h00, 32'h0000_0005, 4'hF, 0, 1'b0, 0, rd, er, lat);
        chk("st0_lat", 0, 32'(lat), 32'd3);
        chk("st0_err", 0, 32'(er), 32'd0);
        chk("st0_rdata", 0, rd, 32'd0);
        txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("ld0_rdata", 0, rd, 32'h0000_0005);
        chk("ld0_lat", 0, 32'(lat), 32'd3);

        txn(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'hF, 0, 1'b0, 0, rd, er, lat);
        txn(0, 1'b1, 32'h04, 32'h1122_3344, 4'b0101, 0, 1'b0, 0, rd, er, lat);
        txn(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("strb_rdata", 0, rd, 32'hAA22_CC44);

        txn(0, 1'b0, 32'h02, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("mis_err", 0, 32'(er), 32'd1);
        chk("mis_rdata", 0, rd, 32'd0);
        txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 0, rd, er, lat);
        chk("oor_err", 0, 32'(er), 32'd1);
        txn(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("nostrb_err", 0, 32'(er), 32'd0);
        txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("after_err_rdata", 0, rd, 32'h0000_0005);

        // Back-pressure with a second request held valid throughout
        txn(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 5, 1'b1, 32'h08, rd, er, lat);
        txn(0, 1'b0, 32'h08, 32'h0, 4'h0, 5, 1'b0, 0, rd, er, lat);
        chk("bp_rdata", 0, rd, 32'hDEAD_BEEF);
        chk("bp_lat", 0, 32'(lat), 32'd3);

        // Reset during the wait states of a store
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h08;
        req_wdata[0] = 32'h1234_5678; req_wstrb[0] = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        @(negedge clk); #1; reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("mid_rst_old", 0, rd, 32'hDEAD_BEEF);

        // Lane 1, LATENCY=0
        txn(1, 1'b1, 32'h0C, 32'h0000_0077, 4'hF, 0, 1'b0, 0, rd, er, lat);
        chk("l0_st_lat", 1, 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("l0_ld_lat", 1, 32'(lat), 32'd1);
        chk("l0_ld_rdata", 1, rd, 32'h0000_0077);
        txn(1, 1'b1, 32'hFC, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 0, rd, er, lat);
        chk("l0_top_err", 1, 32'(er), 32'd0);
        txn(1, 1'b0, 32'hFC, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("l0_top_rdata", 1, rd, 32'hCAFE_F00D);
        txn(1, 1'b0, 32'h101, 32'h0, 4'h0, 0, 1'b0, 0, rd, er, lat);
        chk("l0_oor_err", 1, 32'(er), 32'd1);

        // Seed words used by random traffic
        for (int g = 0; g < 2; g++)
            for (int w = 0; w < 8; w++)
                txn(g, 1'b1, 32'(w) << 2, $urandom, 4'hF, 0, 1'b0, 0, rd, er, lat);

        // Random traffic on both lanes; the model checks every cycle
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                req_valid[g] = ($urandom_range(0, 3) != 0);
                req_we[g]    = 1'($urandom);
                req_addr[g]  = rand_addr();
                req_wdata[g] = $urandom;
                req_wstrb[g] = 4'($urandom);
                rsp_ready[g] = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            rsp_ready[g] = 1'b1;
        end
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready request channel, models a fixed number of wait states, performs the word access with byte strobes, and returns a response over a valid/ready response channel. It sits between the MEM stage (or a future stalling LSU) and the data RAM. It replaces the zero-latency combinational `dmem` so the pipeline can be exercised against a realistic, back-pressuring memory.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of two, ≥ 2.
- `LATENCY`, 2: wait states between acceptance and the access edge; range 0–15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_wstrb`  in  4  byte-lane enables for stores; bit i → `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch we/addr/wdata/wstrb.
  - LATENCY=0: perform the access at this edge and go to RESP.
  - Otherwise load the wait counter with LATENCY−1 and go to WAIT.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 0, perform the access at that edge and go to RESP.
- Access:
  - Error when `addr[1:0]`≠0 or `addr[31:2]` ≥ DEPTH. On error: no write, `rdata`=0, `err`=1.
  - Store: write only the enabled byte lanes of word `addr[log2(DEPTH)+1:2]`. `rdata`=0.
  - Store with `wstrb`=0: legal no-op, returns `err`=0.
  - Load: register the full word.
  - Response registers (`rsp_rdata`, `rsp_err`) load at the access edge.
- RESP: `rsp_valid`=1. Data and err stay stable until `rsp_ready`=1. On handshake, go to IDLE.
- One transaction outstanding at most. No request is accepted in the cycle of a response handshake.
- Request inputs are ignored when `req_ready`=0. Their changes during WAIT/RESP have no effect.
- Memory array is not cleared by reset and has no initial contents. Loads from never-written words return X in simulation.

## Timing
- Reset (async assert, sync deassert by the system) puts the outputs at: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
- Reset mid-transaction: the transaction is dropped with no response. A store that has not yet reached its access edge does not modify memory.
- Latency: `rsp_valid` rises exactly LATENCY+1 cycles after the acceptance edge, assuming `rsp_ready` is not needed to get there.
- Best-case throughput is one transaction per LATENCY+2 cycles: acceptance, LATENCY waits, then one RESP cycle with `rsp_ready`=1. `req_ready` is high again the cycle after the handshake.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely. Memory is unaffected while held.
- Read-after-write: a load accepted after a store's response sees the stored data.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `rsp_ready` to any output.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` (IDLE, WAIT, RESP);
  - `DMEM_WORD_W`=32;
  - `DMEM_STRB_W`=4;
  - request struct `dmem_req_t` (we, addr, wdata, wstrb).
- Sub-module `dmem_array`: DEPTH×32 synchronous RAM.
  - Ports: `clk`, `en`, `we`, `wstrb[3:0]`, `addr`, `wdata`, `rdata`.
  - Registered read; read and write share the same edge; a write returns old data, and the store response is 0 regardless.
- `dmem_responder` holds the FSM, counter, request latch, range check and response registers.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles, release -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Store/load, LATENCY=2:
  - store 0x0000_0005 to 0x00 with `wstrb`=4'hF -> `rsp_valid` exactly 3 cycles after acceptance, `err`=0, `rdata`=0;
  - then load 0x00 -> `rdata`=0x0000_0005.
- Byte strobes: store 0xAABB_CCDD to 0x04, then store 0x1122_3344 with `wstrb`=4'b0101, then load 0x04 -> 0xAA22_CC44.
- Errors:
  - load 0x02 -> `err`=1, `rdata`=0;
  - store 0x100 with DEPTH=64 -> `err`=1;
  - a subsequent load of word 0 returns unchanged data.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP -> `rsp_valid` and `rdata` stable, `req_ready`=0, and a second `req_valid` is not accepted until the cycle after the handshake.
- Reset mid-operation plus LATENCY=0:
  - assert `reset_n`=0 during WAIT of a store to 0x08 -> no response, and a later load 0x08 shows the old value;
  - with LATENCY=0, `rsp_valid` rises 1 cycle after acceptance.
